// File: rtl/mem_arbiter.sv
// Two-port arbiter for one synchronous memory: round-robin with a one-cycle burst lock.
// Latency: grant/ack same cycle as request, read data returned one cycle after issue.
// Backpressure: a requester holds req and its fields until ack; the loser simply waits.
module mem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              resetN,
   // requester 0: processor fetch/operand port
   input  logic              req0,
   input  logic              we0,
   input  logic              lock0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   // requester 1: loader/debug port
   input  logic              req1,
   input  logic              we1,
   input  logic              lock1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   // memory side
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memDataWrite,
   output logic              memWrite,
   output logic              memStrobe,
   input  logic [DATA_W-1:0] memDataRead
);

   // arbitration history and read-return tracking
   logic lastGrant_q, lastGrant_d;
   logic lockVld_q,   lockVld_d;
   logic lockOwner_q, lockOwner_d;
   logic pendRead_q,  pendRead_d;
   logic pendOwner_q, pendOwner_d;

   // current-cycle grant
   logic              gnt_vld;
   logic              gnt_sel;
   logic              sel_we;
   logic              sel_lock;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // Pick the winner; a lock only matters under contention, so an idle lock owner never blocks.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_sel = 1'b0;
      if (resetN) begin
         if (req0 && req1) begin
            gnt_vld = 1'b1;
            gnt_sel = lockVld_q ? lockOwner_q : ~lastGrant_q;
         end else if (req0) begin
            gnt_vld = 1'b1;
            gnt_sel = 1'b0;
         end else if (req1) begin
            gnt_vld = 1'b1;
            gnt_sel = 1'b1;
         end
      end
   end

   // Mux the winning requester's fields
   always_comb begin
      sel_we    = gnt_sel ? we1    : we0;
      sel_lock  = gnt_sel ? lock1  : lock0;
      sel_addr  = gnt_sel ? addr1  : addr0;
      sel_wdata = gnt_sel ? wdata1 : wdata0;
   end

   // Drive the memory and acks; everything is zero when nothing is issued
   always_comb begin
      memStrobe    = gnt_vld;
      memWrite     = gnt_vld & sel_we;
      memAddr      = gnt_vld ? sel_addr : '0;
      memDataWrite = (gnt_vld && sel_we) ? sel_wdata : '0;
      ack0         = gnt_vld & ~gnt_sel;
      ack1         = gnt_vld &  gnt_sel;
   end

   // Next-state: remember the winner, arm a one-cycle lock, and note a pending read
   always_comb begin
      lastGrant_d = lastGrant_q;
      lockVld_d   = 1'b0;
      lockOwner_d = lockOwner_q;
      pendRead_d  = 1'b0;
      pendOwner_d = pendOwner_q;
      if (gnt_vld) begin
         lastGrant_d = gnt_sel;
         lockVld_d   = sel_lock;
         lockOwner_d = gnt_sel;
         pendRead_d  = ~sel_we;
         pendOwner_d = gnt_sel;
      end
   end

   // State register; reset favours requester 0 on the first contention
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         lastGrant_q <= 1'b1;
         lockVld_q   <= 1'b0;
         lockOwner_q <= 1'b0;
         pendRead_q  <= 1'b0;
         pendOwner_q <= 1'b0;
      end else begin
         lastGrant_q <= lastGrant_d;
         lockVld_q   <= lockVld_d;
         lockOwner_q <= lockOwner_d;
         pendRead_q  <= pendRead_d;
         pendOwner_q <= pendOwner_d;
      end
   end

   // Steer returning read data to whoever issued the read; registered flags only, so
   // memDataRead never reaches the ack/strobe logic
   always_comb begin
      rvalid0 = pendRead_q & ~pendOwner_q;
      rvalid1 = pendRead_q &  pendOwner_q;
      rdata0  = rvalid0 ? memDataRead : '0;
      rdata1  = rvalid1 ? memDataRead : '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous memory.
// Inputs change 1 ns after each rising edge, outputs are sampled 2 ns after it.
// Memory contents: addr 0x02 holds 0x1C, every other address holds addr^0x5A.
module tb_mem_arbiter;

   logic       clk = 1'b0;
   logic       resetN;
   logic       req0, we0, lock0, req1, we1, lock1;
   logic [7:0] addr0, wdata0, addr1, wdata1;
   logic       ack0, rvalid0, ack1, rvalid1;
   logic [7:0] rdata0, rdata1;
   logic [7:0] memAddr, memDataWrite, memDataRead;
   logic       memWrite, memStrobe;

   int checks   = 0;
   int failures = 0;

   logic [7:0] mem [256];

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk(clk), .resetN(resetN),
      .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
      .ack0(ack0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
      .ack1(ack1), .rvalid1(rvalid1), .rdata1(rdata1),
      .memAddr(memAddr), .memDataWrite(memDataWrite), .memWrite(memWrite),
      .memStrobe(memStrobe), .memDataRead(memDataRead)
   );

   function automatic logic [7:0] mem_init(input int a);
      logic [7:0] v;
      v = 8'(a) ^ 8'h5A;
      if (a == 2) v = 8'h1C;
      return v;
   endfunction

   // synchronous memory model, one-cycle read latency; reloaded while reset is low
   always @(posedge clk) begin
      if (!resetN) begin
         for (int i = 0; i < 256; i++) mem[i] <= mem_init(i);
         memDataRead <= 8'h00;
      end else if (memStrobe) begin
         if (memWrite) mem[memAddr] <= memDataWrite;
         else          memDataRead  <= mem[memAddr];
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic r0, input logic w0, input logic l0, input logic [7:0] a0,
                        input logic [7:0] d0, input logic r1, input logic w1, input logic l1,
                        input logic [7:0] a1, input logic [7:0] d1);
      req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
   endtask

   // advance to the next cycle's drive point
   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic do_reset;
      resetN = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      resetN = 1'b1;
   endtask

   // per-cycle check of grant outcome: g = -1 none, 0 or 1
   task automatic check_grant(input string tag, input int g, input logic [7:0] a);
      check({tag, ".ack0"},   32'(ack0),      32'(g == 0));
      check({tag, ".ack1"},   32'(ack1),      32'(g == 1));
      check({tag, ".strobe"}, 32'(memStrobe), 32'(g >= 0));
      check({tag, ".addr"},   32'(memAddr),   32'((g >= 0) ? a : 8'h00));
   endtask

   task automatic check_ret(input string tag, input int owner, input logic [7:0] d);
      check({tag, ".rvalid0"}, 32'(rvalid0), 32'(owner == 0));
      check({tag, ".rvalid1"}, 32'(rvalid1), 32'(owner == 1));
      check({tag, ".rdata0"},  32'(rdata0),  32'((owner == 0) ? d : 8'h00));
      check({tag, ".rdata1"},  32'(rdata1),  32'((owner == 1) ? d : 8'h00));
   endtask

   initial begin
      resetN = 1'b0;
      drive(1, 0, 0, 8'h33, 8'h44, 1, 1, 0, 8'h55, 8'h66);
      #3;
      // outputs must stay quiet while reset is held, even with requests pending
      check_grant("rst", -1, 8'h00);
      check("rst.memWrite", 32'(memWrite),     32'h0);
      check("rst.memDataW", 32'(memDataWrite), 32'h0);
      check_ret("rst", -1, 8'h00);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      do_reset;

      // single read from requester 0
      drive(1, 0, 0, 8'h02, 8'h00, 0, 0, 0, 8'h00, 8'h00);
      settle;
      check_grant("rd0", 0, 8'h02);
      check("rd0.memWrite", 32'(memWrite), 32'h0);
      check_ret("rd0", -1, 8'h00);
      next_cycle;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle;
      check_grant("rd0.ret", -1, 8'h00);
      check_ret("rd0.ret", 0, 8'h1C);

      // requester 1 write, then read back
      next_cycle;
      drive(0, 0, 0, 0, 0, 1, 1, 0, 8'h10, 8'hA5);
      settle;
      check_grant("wr1", 1, 8'h10);
      check("wr1.memWrite", 32'(memWrite),     32'h1);
      check("wr1.memDataW", 32'(memDataWrite), 32'hA5);
      check_ret("wr1", -1, 8'h00);
      next_cycle;
      drive(0, 0, 0, 0, 0, 1, 0, 0, 8'h10, 8'hA5);
      settle;
      check_grant("rd1", 1, 8'h10);
      check("rd1.memWrite", 32'(memWrite),     32'h0);
      check("rd1.memDataW", 32'(memDataWrite), 32'h0);
      check_ret("rd1.nowr", -1, 8'h00);
      next_cycle;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle;
      check_ret("rd1.ret", 1, 8'hA5);

      // contention after reset: strict alternation starting with requester 0
      next_cycle;
      do_reset;
      drive(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h01, 8'h00);
      settle;
      check_grant("alt0", 0, 8'h00);
      check_ret("alt0", -1, 8'h00);
      next_cycle; settle;
      check_grant("alt1", 1, 8'h01);
      check_ret("alt1", 0, 8'h5A);
      next_cycle; settle;
      check_grant("alt2", 0, 8'h00);
      check_ret("alt2", 1, 8'h5B);
      next_cycle; settle;
      check_grant("alt3", 1, 8'h01);
      check_ret("alt3", 0, 8'h5A);
      next_cycle;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle;
      check_grant("alt.idle", -1, 8'h00);
      check_ret("alt.end", 1, 8'h5B);

      // burst lock: lock0 on three cycles holds the memory for four grants
      next_cycle;
      drive(1, 0, 1, 8'h20, 8'h00, 1, 0, 0, 8'h21, 8'h00);
      settle;
      check_grant("lk0", 0, 8'h20);
      next_cycle; settle;
      check_grant("lk1", 0, 8'h20);
      check_ret("lk1", 0, 8'h7A);
      next_cycle; settle;
      check_grant("lk2", 0, 8'h20);
      next_cycle;
      lock0 = 1'b0;
      settle;
      check_grant("lk3", 0, 8'h20);
      next_cycle; settle;
      check_grant("lk4", 1, 8'h21);
      check_ret("lk4", 0, 8'h7A);

      // a lock owner that stops requesting does not block the other side
      next_cycle;
      drive(1, 0, 1, 8'h22, 8'h00, 1, 0, 0, 8'h23, 8'h00);
      settle;
      check_grant("lkown", 0, 8'h22);
      next_cycle;
      drive(0, 0, 0, 0, 0, 1, 0, 0, 8'h23, 8'h00);
      settle;
      check_grant("lkidle", 1, 8'h23);

      // read issued, then reset asserted mid-cycle
      next_cycle;
      drive(1, 0, 0, 8'h02, 8'h00, 0, 0, 0, 8'h00, 8'h00);
      settle;
      check_grant("prerst", 0, 8'h02);
      #2;
      resetN = 1'b0;
      #1;
      check_grant("midrst", -1, 8'h00);
      check("midrst.memWrite", 32'(memWrite), 32'h0);
      check_ret("midrst", -1, 8'h00);
      next_cycle;
      check_ret("inrst", -1, 8'h00);
      resetN = 1'b1;
      drive(1, 0, 0, 8'h04, 8'h00, 1, 0, 0, 8'h05, 8'h00);
      settle;
      check_ret("postrst", -1, 8'h00);
      check_grant("postrst", 0, 8'h04);

      // lock set by requester 1, then an idle cycle clears it
      next_cycle;
      lock1 = 1'b1;
      settle;
      check_grant("lk1set", 1, 8'h05);
      next_cycle;
      drive(0, 0, 0, 8'h77, 8'h00, 0, 0, 1, 8'h88, 8'h00);
      settle;
      check_grant("idle", -1, 8'h00);
      check("idle.memDataW", 32'(memDataWrite), 32'h0);
      next_cycle;
      drive(1, 0, 0, 8'h06, 8'h00, 1, 0, 0, 8'h07, 8'h00);
      settle;
      check_grant("afteridle", 0, 8'h06);

      next_cycle;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single synchronous program/data memory between two requesters.
- Requester 0 is the processor fetch/operand port. Requester 1 is the loader/debug port, which writes programs and peeks memory.
- Issues at most one memory access per cycle and uses round-robin on contention, with an optional lock for back-to-back bursts.
- Routes the 1-cycle-latency read data back to the requester that issued the read.

Parameters:
- ADDR_W, 8, address width of memory and requesters.
- DATA_W, 8, data width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- resetN  in  1  reset, asynchronous, active-low.
- req0  in  1  requester 0 access request; addr0/we0/wdata0 held stable while req0=1 and ack0=0.
- we0  in  1  requester 0 write (1) / read (0).
- lock0  in  1  requester 0 keeps priority for its next request.
- addr0  in  ADDR_W  requester 0 address.
- wdata0  in  DATA_W  requester 0 write data.
- ack0  out  1  request accepted this cycle (combinational).
- rvalid0  out  1  read data for requester 0 valid this cycle.
- rdata0  out  DATA_W  read data for requester 0.
- req1, we1, lock1, addr1, wdata1, ack1, rvalid1, rdata1: same as above, for requester 1.
- memAddr  out  ADDR_W  memory address.
- memDataWrite  out  DATA_W  memory write data.
- memWrite  out  1  write enable, qualified by memStrobe.
- memStrobe  out  1  memory access this cycle.
- memDataRead  in  DATA_W  memory read data, valid the cycle after a read strobe.

Behaviour:
- Reset (resetN=0, asynchronous): lastGrant=1, lockOwner=none, pendRead=0, pendOwner=0.
  - Consequence: rvalid0=rvalid1=0 and rdata0/rdata1 read as 0.
  - Combinational outputs during reset: ack0=ack1=0, memStrobe=0, memWrite=0, memAddr=0, memDataWrite=0.
  - A read issued in the cycle before reset produces no rvalid.
- Grant decision (combinational, each cycle):
  - Only req0: grant 0. Only req1: grant 1. Neither: no grant, memStrobe=0, memAddr/memDataWrite=0.
  - Both requesting, lockOwner=k: grant k.
  - Both requesting, no lock: grant the requester that is not lastGrant (strict alternation).
- Issue: for grant g, memStrobe=1, memAddr=addr_g, memWrite=we_g, memDataWrite=wdata_g (0 when reading). ackg=1 in the same cycle; the other ack stays 0.
- On the clock edge with a grant:
  - lastGrant<=g.
  - lockOwner<=g if lock_g=1, else none. A lock lasts one following cycle per assertion; re-asserting lock chains bursts.
  - A lock held by a requester whose req is low does not block the other: a grant goes to whichever requester is requesting.
  - pendRead<=~we_g, pendOwner<=g.
- On the clock edge with no grant: pendRead<=0 and lockOwner<=none.
- Read return: in the cycle after a read issue, rvalid_pendOwner=1 and rdata_pendOwner=memDataRead. The other rvalid=0 and its rdata=0.
- Writes produce ack only, never rvalid.
- Throughput: one access per cycle. Back-to-back reads from one requester give rvalid every cycle.
- A requester may change its request fields in the cycle its ack is 1. A newly raised req can be granted in the same cycle.
- Address and data pass through unmodified; no wrap or arithmetic is applied.
- Timing: no combinational path from memDataRead to any ack/strobe output.

Test Plan:
- Reset then req0 read addr 0x02, memory[0x02]=0x1C -> ack0=1 in the request cycle, rvalid0=1 with rdata0=0x1C one cycle later, rvalid1=0 throughout.
- req1 write addr 0x10 data 0xA5, then req1 read 0x10 -> first cycle memWrite=1, memDataWrite=0xA5, ack1=1, no rvalid1; next cycle read ack1=1; following cycle rdata1=0xA5.
- req0 and req1 both held high reading 0x00/0x01 for 4 cycles after reset -> grants 0,1,0,1; rvalid alternates 0/1 with correct data routing.
- Both requesting, lock0=1 for 3 consecutive cycles -> grants 0,0,0,0; then lock0=0 -> next grant 1.
- Read issued, resetN pulled low mid-cycle before the next edge -> all outputs 0 immediately, no rvalid after release. First contended grant after release goes to requester 0.
- Idle cycles (no req) -> memStrobe=0, memAddr=0. A lock set before an idle cycle is cleared, so the next contention uses alternation.
